// File: rtl/if_stage_if.sv
// Instruction-memory fetch handshake: one outstanding request, held until ack.
// master = fetch stage (drives req/addr), slave = memory (drives ack/rdata).
interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID register, delayed-branch redirect and delay-slot tagging.
// Optional macro IF_FETCH_BUF_EN keeps a word acked during a stall instead of re-fetching it.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [31:0]       branch_target_i,
  input  logic              next_inst_in_delayslot_i,
  if_stage_if.master        imem,
  output logic [31:0]       id_pc_o,
  output logic [31:0]       id_inst_o,
  output logic              id_valid_o,
  output logic              id_is_in_delayslot_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_reg;
  logic [31:0] fetch_pc_reg;
  logic [31:0] addr_reg;
  logic        req_reg;
  logic        redir_pend_reg;
  logic [31:0] redir_pc_reg;
  logic        ds_pend_reg;
  logic [31:0] id_pc_reg;
  logic [31:0] id_inst_reg;
  logic        id_valid_reg;
  logic        id_ds_reg;
`ifdef IF_FETCH_BUF_EN
  logic [31:0] buf_inst_reg;
`endif

  logic        take_branch;
  logic        ds_next_issue;
  logic        issue;
  logic [31:0] next_pc;
  logic [31:0] next_addr;

  // A redirect already pending wins over one arriving this cycle: it is the older branch.
  assign take_branch   = branch_flag_i & ~stall_i;
  assign ds_next_issue = ds_pend_reg | (next_inst_in_delayslot_i & ~stall_i);
  assign next_pc       = redir_pend_reg ? redir_pc_reg :
                         (take_branch ? branch_target_i : fetch_pc_reg + 32'd4);
  assign next_addr     = {next_pc[31:2], 2'b00};

  // issue = a real instruction is loaded into IF/ID this cycle
  always_comb begin
    issue = 1'b0;
    if (!stall_i) begin
      if (state_reg == S_FETCH && imem.ack) begin
        issue = 1'b1;
      end
`ifdef IF_FETCH_BUF_EN
      if (state_reg == S_HOLD) begin
        issue = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= S_IDLE;
      fetch_pc_reg   <= RESET_PC;
      addr_reg       <= '0;
      req_reg        <= 1'b0;
      redir_pend_reg <= 1'b0;
      redir_pc_reg   <= '0;
      ds_pend_reg    <= 1'b0;
      id_pc_reg      <= '0;
      id_inst_reg    <= NOP_INST;
      id_valid_reg   <= 1'b0;
      id_ds_reg      <= 1'b0;
`ifdef IF_FETCH_BUF_EN
      buf_inst_reg   <= '0;
`endif
    end else begin
      // Pending flags survive bubbles and are frozen by a stall.
      if (!stall_i) begin
        if (issue) begin
          redir_pend_reg <= 1'b0;
          ds_pend_reg    <= 1'b0;
        end else begin
          if (branch_flag_i) begin
            redir_pend_reg <= 1'b1;
            redir_pc_reg   <= branch_target_i;
          end
          if (next_inst_in_delayslot_i) begin
            ds_pend_reg <= 1'b1;
          end
        end
      end

      case (state_reg)
        S_IDLE: begin
          state_reg <= S_FETCH;
          req_reg   <= 1'b1;
          addr_reg  <= {fetch_pc_reg[31:2], 2'b00};
        end

        S_FETCH: begin
          if (imem.ack && !stall_i) begin
            id_pc_reg    <= fetch_pc_reg;
            id_inst_reg  <= imem.rdata;
            id_valid_reg <= 1'b1;
            id_ds_reg    <= ds_next_issue;
            fetch_pc_reg <= next_pc;
            addr_reg     <= next_addr;
          end else if (imem.ack) begin
            state_reg    <= S_HOLD;
            req_reg      <= 1'b0;
`ifdef IF_FETCH_BUF_EN
            buf_inst_reg <= imem.rdata;
`endif
          end else if (!stall_i) begin
            id_inst_reg  <= NOP_INST;
            id_valid_reg <= 1'b0;
            id_ds_reg    <= 1'b0;
          end
        end

        S_HOLD: begin
          if (!stall_i) begin
            state_reg <= S_FETCH;
            req_reg   <= 1'b1;
`ifdef IF_FETCH_BUF_EN
            id_pc_reg    <= fetch_pc_reg;
            id_inst_reg  <= buf_inst_reg;
            id_valid_reg <= 1'b1;
            id_ds_reg    <= ds_next_issue;
            fetch_pc_reg <= next_pc;
            addr_reg     <= next_addr;
`else
            // The discarded word is re-requested from the unchanged fetch_pc.
            id_inst_reg  <= NOP_INST;
            id_valid_reg <= 1'b0;
            id_ds_reg    <= 1'b0;
`endif
          end
        end

        default: begin
          state_reg <= S_IDLE;
          req_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign imem.req             = req_reg;
  assign imem.addr            = addr_reg;
  assign id_pc_o              = id_pc_reg;
  assign id_inst_o            = id_inst_reg;
  assign id_valid_o           = id_valid_reg;
  assign id_is_in_delayslot_o = id_ds_reg;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed fetch/branch/stall/wrap scenarios and a random run,
// all checked every cycle against a transaction-level fetch model.
`timescale 1ns/1ps
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        br = 1'b0;
  logic [31:0] tgt = '0;
  logic        nds = 1'b0;
  logic [31:0] id_pc;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_ds;

  if_stage_if imem();

  if_stage #(.RESET_PC(RESET_PC), .NOP_INST(32'h0000_0000)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .stall_i                  (stall),
    .branch_flag_i            (br),
    .branch_target_i          (tgt),
    .next_inst_in_delayslot_i (nds),
    .imem                     (imem),
    .id_pc_o                  (id_pc),
    .id_inst_o                (id_inst),
    .id_valid_o               (id_valid),
    .id_is_in_delayslot_o     (id_ds)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {~a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- reference model (fetch behaviour as transactions) ----------------
  bit          m_run;
  bit          m_parked;
  logic [31:0] m_buf;
  logic [31:0] m_fpc;
  logic [31:0] m_tq[$];
  bit          m_ds_owed;
  logic [31:0] e_pc, e_inst;
  bit          e_valid, e_ds;

  task automatic model_reset();
    m_run = 0; m_parked = 0; m_buf = '0; m_fpc = RESET_PC;
    m_tq.delete(); m_ds_owed = 0;
    e_pc = '0; e_inst = '0; e_valid = 0; e_ds = 0;
  endtask

  task automatic model_step(input bit s, input bit b, input logic [31:0] t, input bit d,
                            input bit a, input logic [31:0] rd);
    bit          took;
    logic [31:0] word;
    took = 0;
    word = '0;
    if (!m_run) begin
      m_run = 1;
    end else if (m_parked) begin
      if (!s) begin
        m_parked = 0;
`ifdef IF_FETCH_BUF_EN
        took = 1;
        word = m_buf;
`else
        e_inst = '0; e_valid = 0; e_ds = 0;
`endif
      end
    end else if (a && s) begin
      m_parked = 1;
      m_buf = rd;
    end else if (a) begin
      took = 1;
      word = rd;
    end else if (!s) begin
      e_inst = '0; e_valid = 0; e_ds = 0;
    end
    if (s) return;
    if (took) begin
      e_pc = m_fpc; e_inst = word; e_valid = 1; e_ds = d || m_ds_owed;
      if (m_tq.size() != 0) m_fpc = m_tq[0];
      else if (b)           m_fpc = t;
      else                  m_fpc = m_fpc + 32'd4;
      m_tq.delete();
      m_ds_owed = 0;
    end else begin
      if (b) begin
        m_tq.delete();
        m_tq.push_back(t);
      end
      if (d) m_ds_owed = 1;
    end
  endtask

  // ---------------- stimulus knobs ----------------
  int          lat = 1;
  bit          rand_lat = 0;
  int          stall_pct = 0;
  int          br_pct = 0;
  bit          use_knobs = 0;
  logic [31:0] br_pc0 = 32'h1, br_t0 = '0, br_pc1 = 32'h1, br_t1 = '0;
  logic [31:0] stall_addr = 32'h1;
  bit          stall_armed = 0;
  int          stall_cnt = 0;
  int          mem_wait = 0;
  bit          inject_ack = 0;
  int          acks_at_stall_addr = 0;
  bit          prev_stall = 1;
  bit          verbose = 1;
  logic [31:0] iss_pc[$];
  bit          iss_ds[$];

  logic [31:0] exp_br_pc [11] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40, 32'h44, 32'h48,
                                  32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4};
  bit          exp_br_ds [11] = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0};
  logic [31:0] exp_st_pc [7]  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14, 32'h18};

  // Called #1 after a rising edge: check, drive the next cycle, clock the model.
  task automatic step();
    logic        a;
    logic [31:0] rd;
    check_value("req", {31'b0, imem.req}, {31'b0, m_run && !m_parked});
    if (m_run && !m_parked) check_value("addr", imem.addr, {m_fpc[31:2], 2'b00});
    check_value("valid", {31'b0, id_valid}, {31'b0, e_valid});
    check_value("inst", id_inst, e_inst);
    check_value("ds", {31'b0, id_ds}, {31'b0, e_ds});
    check_value("pc", id_pc, e_pc);
    if (id_valid && !prev_stall) begin
      iss_pc.push_back(id_pc);
      iss_ds.push_back(id_ds);
      if (verbose) $display("issue pc=%h inst=%h ds=%0d", id_pc, id_inst, id_ds);
    end

    a  = 1'b0;
    rd = $urandom;
    if (inject_ack) begin
      a = 1'b1;
      inject_ack = 0;
    end else if (imem.req) begin
      if (mem_wait + 1 >= lat) begin
        a = 1'b1;
        mem_wait = 0;
        rd = mem_word(imem.addr);
        if (rand_lat) lat = $urandom_range(1, 4);
      end else begin
        mem_wait++;
      end
    end else begin
      mem_wait = 0;
    end

    br = 1'b0; nds = 1'b0; tgt = $urandom;
    if (id_valid) begin
      if (use_knobs) begin
        if (id_pc == br_pc0) begin br = 1'b1; tgt = br_t0; nds = 1'b1; end
        else if (id_pc == br_pc1) begin br = 1'b1; tgt = br_t1; nds = 1'b1; end
      end else if ($urandom_range(99) < br_pct) begin
        br = 1'b1; nds = 1'b1;
        tgt = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 + (32'($urandom_range(3)) << 2)
                                       : 32'($urandom_range(255)) << 2;
      end
    end

    stall = 1'b0;
    if (stall_cnt > 0) begin
      stall = 1'b1;
      stall_cnt--;
    end else if (stall_armed && a && imem.req && imem.addr == stall_addr) begin
      stall = 1'b1;
      stall_cnt = 1;
      stall_armed = 0;
    end else if ($urandom_range(99) < stall_pct) begin
      stall = 1'b1;
    end
    if (a && imem.req && imem.addr == stall_addr) acks_at_stall_addr++;

    imem.ack   = a;
    imem.rdata = rd;
    @(posedge clk);
    model_step(stall, br, tgt, nds, a, rd);
    prev_stall = stall;
    #1;
  endtask

  // Asynchronous reset mid-cycle; the next cycle after release is the IDLE cycle.
  task automatic do_reset();
    #2;
    rst = 1'b0;
    stall = 1'b0; br = 1'b0; nds = 1'b0; imem.ack = 1'b0;
    #1;
    check_value("rst_req", {31'b0, imem.req}, 32'h0);
    check_value("rst_addr", imem.addr, 32'h0);
    check_value("rst_valid", {31'b0, id_valid}, 32'h0);
    check_value("rst_inst", id_inst, 32'h0);
    check_value("rst_ds", {31'b0, id_ds}, 32'h0);
    check_value("rst_pc", id_pc, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    mem_wait = 0; stall_cnt = 0; prev_stall = 1; acks_at_stall_addr = 0;
    iss_pc.delete(); iss_ds.delete();
    rst = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    int c;
    c = 0;
    while (iss_pc.size() < n && c < budget) begin
      step();
      c++;
    end
    check_value("issue_budget", {31'b0, iss_pc.size() >= n}, 32'h1);
  endtask

  initial begin
    imem.ack = 1'b0;
    imem.rdata = '0;
    @(posedge clk);
    #1;

    // Branch at 8 -> 40 and at 44 -> FFFF_FFF8 (wraps to 0), 1-cycle memory.
    do_reset();
    inject_ack = 1;
    lat = 1; use_knobs = 1;
    br_pc0 = 32'h8; br_t0 = 32'h40; br_pc1 = 32'h44; br_t1 = 32'hFFFF_FFF8;
    run_until(11, 200);
    for (int i = 0; i < 11; i++) begin
      if (i < iss_pc.size()) begin
        check_value($sformatf("br1_pc%0d", i), iss_pc[i], exp_br_pc[i]);
        check_value($sformatf("br1_ds%0d", i), {31'b0, iss_ds[i]}, {31'b0, exp_br_ds[i]});
      end
    end

    // Same program with a 3-cycle memory: delay-slot tag must skip the bubbles.
    do_reset();
    inject_ack = 1;
    lat = 3;
    run_until(11, 400);
    for (int i = 0; i < 11; i++) begin
      if (i < iss_pc.size()) begin
        check_value($sformatf("br3_pc%0d", i), iss_pc[i], exp_br_pc[i]);
        check_value($sformatf("br3_ds%0d", i), {31'b0, iss_ds[i]}, {31'b0, exp_br_ds[i]});
      end
    end

    // Ack for 10 arrives while decode stalls for two cycles.
    do_reset();
    lat = 1; use_knobs = 0; br_pct = 0;
    stall_addr = 32'h10; stall_armed = 1;
    run_until(7, 200);
    for (int i = 0; i < 7; i++) begin
      if (i < iss_pc.size()) check_value($sformatf("st_pc%0d", i), iss_pc[i], exp_st_pc[i]);
    end
`ifdef IF_FETCH_BUF_EN
    check_value("st_acks_at_10", acks_at_stall_addr, 32'd1);
`else
    check_value("st_acks_at_10", acks_at_stall_addr, 32'd2);
`endif

    // Random latency, stalls and branches.
    do_reset();
    stall_addr = 32'h1; stall_armed = 0;
    rand_lat = 1; lat = 2; stall_pct = 25; br_pct = 20; verbose = 0;
    for (int i = 0; i < 1500; i++) step();
    check_value("rand_progress", {31'b0, iss_pc.size() > 50}, 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
